// File: rtl/nvio2_regport_if.sv
// Issue/operand/commit-side bundle of the nvio2 register-file port sequencer.
// master: issue + commit stages (drive requests and write-backs)
// slave : nvio2_regport
interface nvio2_regport_if;
   logic         rd_req;
   logic         rd_rdy;
   logic [6:0]   rd_ctx;
   logic [5:0]   ra;
   logic [5:0]   rb;
   logic [5:0]   rc;
   logic         out_v;
   logic         out_rdy;
   logic [127:0] a;
   logic [127:0] b;
   logic [127:0] c;
   logic         wb_v;
   logic [6:0]   wb_ctx;
   logic [5:0]   wb_reg;
   logic [127:0] wb_data;
   logic         wb_full;

   modport master (
      output rd_req, rd_ctx, ra, rb, rc, out_rdy, wb_v, wb_ctx, wb_reg, wb_data,
      input  rd_rdy, out_v, a, b, c, wb_full
   );

   modport slave (
      input  rd_req, rd_ctx, ra, rb, rc, out_rdy, wb_v, wb_ctx, wb_reg, wb_data,
      output rd_rdy, out_v, a, b, c, wb_full
   );
endinterface

// File: rtl/nvio2_regport.sv
// nvio2_regport: time-multiplexes three-operand fetches and a queued
// write-back stream onto the single 1-cycle-latency register-file port.
// Optional feature macro: NVIO2_RFBYPASS_EN
//   defined   : queued write-backs are forwarded into fetched operands,
//               fetches may start while the write-back FIFO holds entries.
//   undefined : no comparators; a fetch starts only once the FIFO is empty
//               and no write-back is arriving, so the file is always current.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | port free; accept a fetch (read A) or drain one write-back
// RB    | read B, capture A
// RC    | read C, capture B
// CAPC  | capture C; port free for write-back drain
// DONE  | operands valid, waiting for consumer; write-backs may drain
module nvio2_regport #(
   parameter int WDEP = 4
) (
   input  logic           clk,
   input  logic           rst,
   nvio2_regport_if.slave bus,
   output logic           rf_wr,
   output logic [12:0]    rf_adr,
   output logic [127:0]   rf_i,
   input  logic [127:0]   rf_o
);

   localparam int PW = $clog2(WDEP);

   typedef enum logic [2:0] {IDLE, RB, RC, CAPC, DONE} state_t;

   state_t         state;
   state_t         state_nxt;

   logic [6:0]     ctx_q;
   logic [5:0]     rb_q;
   logic [5:0]     rc_q;
   logic [127:0]   a_q;
   logic [127:0]   b_q;
   logic [127:0]   c_q;

   logic [6:0]     q_ctx  [WDEP];
   logic [5:0]     q_reg  [WDEP];
   logic [127:0]   q_data [WDEP];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [PW:0]    count;

   logic           fifo_empty;
   logic           accept;
   logic           push;
   logic           pop;
   logic           drain_ok;
   logic [127:0]   cap_val;

   assign fifo_empty  = (count == '0);
   assign bus.wb_full = (count == (PW+1)'(WDEP));
   // register 0 is hardwired zero in the file, so its writes are never queued
   assign push        = bus.wb_v && !bus.wb_full && (bus.wb_reg != 6'd0);
   assign accept      = bus.rd_req && bus.rd_rdy;
   assign drain_ok    = ((state == IDLE) && !accept) || (state == CAPC) || (state == DONE);
   assign pop         = drain_ok && !fifo_empty && !rst;

   assign bus.out_v   = (state == DONE);
   assign bus.a       = a_q;
   assign bus.b       = b_q;
   assign bus.c       = c_q;

`ifdef NVIO2_RFBYPASS_EN
   assign bus.rd_rdy = (state == IDLE) && !bus.wb_full && !rst;

   logic           iss_act;
   logic [6:0]     iss_ctx;
   logic [5:0]     iss_reg;
   logic           hit;
   logic [127:0]   hit_data;
   logic [PW-1:0]  idx;
   logic           fwd_hit_q;
   logic [127:0]   fwd_data_q;

   // address being issued to the file this cycle, if any
   always_comb begin
      iss_act = 1'b0;
      iss_ctx = ctx_q;
      iss_reg = rb_q;
      case (state)
         IDLE: begin
            iss_act = accept;
            iss_ctx = bus.rd_ctx;
            iss_reg = bus.ra;
         end
         RB: iss_act = 1'b1;
         RC: begin
            iss_act = 1'b1;
            iss_reg = rc_q;
         end
         default: ;
      endcase
   end

   // youngest queued match wins; scan oldest to youngest, same-cycle push last
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int k = 0; k < WDEP; k++) begin
         idx = rd_ptr + PW'(k);
         if (((PW+1)'(k) < count) && (q_ctx[idx] == iss_ctx) &&
             (q_reg[idx] == iss_reg) && (iss_reg != 6'd0)) begin
            hit      = 1'b1;
            hit_data = q_data[idx];
         end
      end
      if (push && (bus.wb_ctx == iss_ctx) && (bus.wb_reg == iss_reg)) begin
         hit      = 1'b1;
         hit_data = bus.wb_data;
      end
   end

   // latch forwarded value at issue so later write-backs cannot disturb it
   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_hit_q  <= 1'b0;
         fwd_data_q <= '0;
      end else begin
         fwd_hit_q  <= iss_act && hit;
         fwd_data_q <= hit_data;
      end
   end

   assign cap_val = fwd_hit_q ? fwd_data_q : rf_o;
`else
   assign bus.rd_rdy = (state == IDLE) && fifo_empty && !bus.wb_v && !rst;
   assign cap_val    = rf_o;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RB;
         RB:      state_nxt = RC;
         RC:      state_nxt = CAPC;
         CAPC:    state_nxt = DONE;
         DONE:    if (bus.out_rdy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // register-file port mux: operand reads take priority, drains fill idle slots
   always_comb begin
      rf_wr  = 1'b0;
      rf_adr = '0;
      rf_i   = '0;
      if (!rst) begin
         case (state)
            IDLE:    if (accept) rf_adr = {bus.rd_ctx, bus.ra};
            RB:      rf_adr = {ctx_q, rb_q};
            RC:      rf_adr = {ctx_q, rc_q};
            default: ;
         endcase
         if (pop) begin
            rf_wr  = 1'b1;
            rf_adr = {q_ctx[rd_ptr], q_reg[rd_ptr]};
            rf_i   = q_data[rd_ptr];
         end
      end
   end

   // write-back FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   // write-back FIFO storage; contents are qualified by count, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         q_ctx[wr_ptr]  <= bus.wb_ctx;
         q_reg[wr_ptr]  <= bus.wb_reg;
         q_data[wr_ptr] <= bus.wb_data;
      end
   end

   // fetch context and operand capture
   always_ff @(posedge clk) begin
      if (rst) begin
         ctx_q <= '0;
         rb_q  <= '0;
         rc_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= '0;
      end else begin
         if (accept) begin
            ctx_q <= bus.rd_ctx;
            rb_q  <= bus.rb;
            rc_q  <= bus.rc;
         end
         if (state == RB)   a_q <= cap_val;
         if (state == RC)   b_q <= cap_val;
         if (state == CAPC) c_q <= cap_val;
      end
   end

endmodule

// File: doc/nvio2_regport.md
# nvio2_regport

Port sequencer directly upstream of the nvio2 register file: time-multiplexes three-operand fetches and a queued write-back stream onto the file's single 13-bit-address, 1-cycle-latency port. Each operand fetch reads registers A, B and C of one context, forwards still-queued write-back data, and presents the operands with a valid/ready handshake. Sits between the issue stage (reads) and the commit stage (write-backs).

## Interface
- WDEP, 4: write-back FIFO depth, power of two, 2..16
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- rd_req  in  1  operand fetch request
- rd_rdy  out  1  fetch accepted when rd_req && rd_rdy
- rd_ctx  in  7  context, upper address bits [12:6]
- ra, rb, rc  in  6 each  source register numbers, address bits [5:0]
- out_v  out  1  operands valid
- out_rdy  in  1  consumer takes operands when out_v && out_rdy
- a, b, c  out  128 each  operand values
- wb_v  in  1  write-back valid
- wb_ctx  in  7  write-back context
- wb_reg  in  6  write-back register
- wb_data  in  128  write-back value
- wb_full  out  1  FIFO full; wb_v ignored while high
- rf_wr  out  1  register-file write enable
- rf_adr  out  13  register-file address, {ctx, reg}
- rf_i  out  128  register-file write data
- rf_o  in  128  register-file read data, valid the cycle after rf_adr is driven

## Operation
- States: IDLE, RB, RC, CAPC, DONE.
- IDLE: rd_rdy = !wb_full (see Configuration). On accept: rf_adr = {rd_ctx, ra}, rf_wr=0; ctx, rb, rc latched; go RB. Otherwise, if FIFO not empty: pop oldest, rf_wr=1, rf_adr/rf_i from entry.
- RB: rf_adr = {ctx, rb}; capture rf_o into a; go RC.
- RC: rf_adr = {ctx, rc}; capture b; go CAPC.
- CAPC: capture c; go DONE; port free, FIFO may drain.
- DONE: out_v=1; a/b/c stable; on out_rdy, go IDLE. FIFO may drain.
- rf_wr only in IDLE (no accept), CAPC, DONE; rf_wr=0 in RB/RC and during the accept cycle.
- FIFO push: wb_v && !wb_full && wb_reg!=0. Writes to register 0 are discarded. Push and pop in the same cycle are both allowed; count unchanged.
- Register 0 reads return zero via the register file; forwarding never matches register 0.
- Forwarding: at each issue cycle, {ctx, reg} is compared against all valid FIFO entries and against the same-cycle push; youngest match wins (same-cycle push is youngest). A match replaces the captured rf_o value in the following cycle. Forwarded value is latched at issue; later write-backs do not alter the operand.
- wb_full = (count == WDEP).

## Timing
- Reset: state IDLE, FIFO empty, out_v=0, rd_rdy=0 for the reset cycle, rf_wr=0, rf_adr=0, a=b=c=0, wb_full=0.
- Fetch accepted cycle N: out_v first high in cycle N+4; back-to-back fetch accept at earliest N+5 (out_rdy held high).
- Write-back pushed cycle N is written to the file no earlier than cycle N+1.
- rst mid-fetch aborts the fetch; queued write-backs are lost.

## Configuration
- NVIO2_RFBYPASS_EN defined: forwarding as above; rd_rdy = IDLE && !wb_full.
- Undefined: no comparators; rd_rdy = IDLE && FIFO empty && !wb_v, so every pending write reaches the file before any read is issued. Latency unchanged.

## Test plan
- Write ctx 3 r5=0x11..11 via wb_v, wait 3 cycles, fetch ctx 3 ra=5 rb=0 rc=5 -> out_v at N+4, a=c=0x11..11, b=0.
- Push wb ctx 1 r7=0xAB in the accept cycle of fetch ctx 1 ra=7 (bypass on) -> a=0xAB; bypass off -> rd_rdy low that cycle, fetch accepted after drain, a=0xAB.
- Two queued writes to ctx 2 r9 (0x1 then 0x2), fetch rb=9 before drain -> b=0x2.
- Push WDEP writes with no drain possible (fetch in RB) -> wb_full=1, extra wb_v dropped; entries drain in CAPC/DONE in order.
- Hold out_rdy low 10 cycles in DONE -> a/b/c stable, FIFO fully drains, rd_rdy=0.
- Assert rst in RC -> next cycle out_v=0, wb_full=0, state IDLE, rf_wr=0.
